// File: rtl/phase_seq_pkg.sv
// Shared definitions for the multi-phase instruction-cycle sequencer:
// FSM state encoding and a width helper used to size the slot counter.
package phase_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // Bits needed to index n slots, never less than one.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/phase_onehot_dec.sv
// Turns the current slot index into one-hot phase strobes while in RUN.
module phase_onehot_dec #(
    parameter int unsigned NUM_PHASES = 5,
    parameter int unsigned CNT_W      = 3
) (
    input  logic                  run,
    input  logic [CNT_W-1:0]      slot,
    output logic [NUM_PHASES-1:0] phase_c
);

    always_comb begin
        phase_c = '0;
        if (run) begin
            for (int unsigned i = 0; i < NUM_PHASES; i++) begin
                if (slot == CNT_W'(i)) begin
                    phase_c[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/phase_seq_gen.sv
// Multi-phase sequencer: walks RUN phase slots then GAP idle slots each
// instruction cycle, with stall, halt, single-step and cycle status pulses.
module phase_seq_gen
    import phase_seq_pkg::*;
#(
    parameter int unsigned NUM_PHASES = 5,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned CYC_W      = 16,
    localparam int unsigned CNT_W     = clog2_min1(NUM_PHASES + GAP_CYCLES)
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  step_mode,
    input  logic                  step,
    input  logic                  stall,
    input  logic                  halt,
    output logic [NUM_PHASES-1:0] phase,
    output logic [CNT_W-1:0]      slot,
    output logic                  busy,
    output logic                  cycle_start,
    output logic                  cycle_done,
    output logic [CYC_W-1:0]      cycle_count
);

    localparam int unsigned TOTAL = NUM_PHASES + GAP_CYCLES;
    localparam logic [CNT_W-1:0] LAST_PH   = CNT_W'(NUM_PHASES - 1);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(TOTAL - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   slot_q, slot_d;
    logic               pend_q, pend_d;
    logic               start_q, start_d;
    logic               done_q, done_d;
    logic [CYC_W-1:0]   count_q, count_d;
    logic               go_c;
    logic               launch_c;
    logic               wrap_c;

    assign go_c = en && (!step_mode || pend_q || step);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
            pend_q  <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            pend_q  <= pend_d;
            start_q <= start_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    // Next state and slot; wrap_c marks a completed cycle, launch_c a new slot 0.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        launch_c = 1'b0;
        wrap_c   = 1'b0;
        if (halt) begin
            state_d = ST_IDLE;
            slot_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (go_c) begin
                        state_d  = ST_RUN;
                        slot_d   = '0;
                        launch_c = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        if (slot_q != LAST_PH) begin
                            slot_d = slot_q + CNT_W'(1);
                        end else if (GAP_CYCLES > 0) begin
                            state_d = ST_GAP;
                            slot_d  = slot_q + CNT_W'(1);
                        end else begin
                            wrap_c = 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (!stall) begin
                        if (slot_q != LAST_SLOT) begin
                            slot_d = slot_q + CNT_W'(1);
                        end else begin
                            wrap_c = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    slot_d  = '0;
                end
            endcase
            // Cycle boundary: restart back-to-back or drop to IDLE.
            if (wrap_c) begin
                slot_d = '0;
                if (go_c) begin
                    state_d  = ST_RUN;
                    launch_c = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end
    end

    // Status pulses, completed-cycle count and the single-step latch.
    always_comb begin
        start_d = launch_c;
        done_d  = wrap_c;
        count_d = wrap_c ? count_q + CYC_W'(1) : count_q;
        pend_d  = pend_q;
        if (halt) begin
            pend_d = 1'b0;
        end else if (launch_c && step_mode) begin
            pend_d = 1'b0;
        end else if (step) begin
            pend_d = 1'b1;
        end
    end

    phase_onehot_dec #(
        .NUM_PHASES (NUM_PHASES),
        .CNT_W      (CNT_W)
    ) u_dec (
        .run     (state_q == ST_RUN),
        .slot    (slot_q),
        .phase_c (phase)
    );

    assign slot        = slot_q;
    assign busy        = (state_q != ST_IDLE);
    assign cycle_start = start_q;
    assign cycle_done  = done_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_phase_seq_gen.sv
// Directed bench for phase_seq_gen: default 5+1 instance plus a 4+0 instance.
module tb_phase_seq_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, step_mode, step, stall, halt;
    logic [4:0]  phase;
    logic [2:0]  slot;
    logic        busy, cycle_start, cycle_done;
    logic [15:0] cycle_count;

    logic        rst4_n, en4;
    logic [3:0]  phase4;
    logic [1:0]  slot4;
    logic        busy4, start4, done4;
    logic [15:0] count4;

    int checks   = 0;
    int failures = 0;

    phase_seq_gen u_dut (
        .clk_in      (clk),
        .rst_n       (rst_n),
        .en          (en),
        .step_mode   (step_mode),
        .step        (step),
        .stall       (stall),
        .halt        (halt),
        .phase       (phase),
        .slot        (slot),
        .busy        (busy),
        .cycle_start (cycle_start),
        .cycle_done  (cycle_done),
        .cycle_count (cycle_count)
    );

    phase_seq_gen #(.NUM_PHASES(4), .GAP_CYCLES(0)) u_dut4 (
        .clk_in      (clk),
        .rst_n       (rst4_n),
        .en          (en4),
        .step_mode   (1'b0),
        .step        (1'b0),
        .stall       (1'b0),
        .halt        (1'b0),
        .phase       (phase4),
        .slot        (slot4),
        .busy        (busy4),
        .cycle_start (start4),
        .cycle_done  (done4),
        .cycle_count (count4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string tag, input logic [4:0] ph, input logic bz,
                            input logic st, input logic dn, input logic [15:0] cnt);
        chk({tag, ".phase"}, 32'(phase), 32'(ph));
        chk({tag, ".busy"}, 32'(busy), 32'(bz));
        chk({tag, ".start"}, 32'(cycle_start), 32'(st));
        chk({tag, ".done"}, 32'(cycle_done), 32'(dn));
        chk({tag, ".count"}, 32'(cycle_count), 32'(cnt));
    endtask

    initial begin
        logic [4:0] exp_ph;
        rst_n = 1'b0; en = 1'b0; step_mode = 1'b0; step = 1'b0; stall = 1'b0; halt = 1'b0;
        rst4_n = 1'b0; en4 = 1'b0;
        tick(); tick();
        chk_main("reset", 5'b00000, 1'b0, 1'b0, 1'b0, 16'd0);
        chk("reset.slot", 32'(slot), 32'd0);

        // Free run: 1,2,4,8,16,0 repeating, count 3 after 18 cycles.
        rst_n = 1'b1; en = 1'b1;
        tick();
        for (int i = 0; i <= 18; i++) begin
            exp_ph = ((i % 6) < 5) ? (5'b00001 << (i % 6)) : 5'b00000;
            chk_main($sformatf("free%0d", i), exp_ph, 1'b1, (i % 6) == 0,
                     (i % 6) == 0 && i > 0, 16'(i / 6));
            chk($sformatf("free%0d.slot", i), 32'(slot), 32'(i % 6));
            if (i < 18) tick();
        end

        // Stall 3 cycles in phase[2], then 1 cycle at the gap/boundary slot.
        tick(); tick();
        chk_main("pre_stall", 5'b00100, 1'b1, 1'b0, 1'b0, 16'd3);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_main($sformatf("stall%0d", i), 5'b00100, 1'b1, 1'b0, 1'b0, 16'd3);
        end
        stall = 1'b0;
        tick(); chk_main("post_stall_p3", 5'b01000, 1'b1, 1'b0, 1'b0, 16'd3);
        tick(); chk_main("post_stall_p4", 5'b10000, 1'b1, 1'b0, 1'b0, 16'd3);
        tick(); chk_main("post_stall_gap", 5'b00000, 1'b1, 1'b0, 1'b0, 16'd3);
        stall = 1'b1;
        tick(); chk_main("stall_boundary", 5'b00000, 1'b1, 1'b0, 1'b0, 16'd3);
        chk("stall_boundary.slot", 32'(slot), 32'd5);
        stall = 1'b0;
        tick(); chk_main("after_boundary", 5'b00001, 1'b1, 1'b1, 1'b1, 16'd4);

        // Halt during phase[3] with stall also high: halt wins.
        tick(); tick(); tick();
        chk_main("pre_halt", 5'b01000, 1'b1, 1'b0, 1'b0, 16'd4);
        halt = 1'b1; stall = 1'b1;
        tick(); chk_main("halt", 5'b00000, 1'b0, 1'b0, 1'b0, 16'd4);
        chk("halt.slot", 32'(slot), 32'd0);
        halt = 1'b0; stall = 1'b0;
        tick(); chk_main("restart", 5'b00001, 1'b1, 1'b1, 1'b0, 16'd4);

        // en dropped mid-cycle: cycle completes, one done, then IDLE.
        tick(); en = 1'b0;
        tick(); chk_main("en_off_p2", 5'b00100, 1'b1, 1'b0, 1'b0, 16'd4);
        tick(); tick(); tick();
        chk_main("en_off_gap", 5'b00000, 1'b1, 1'b0, 1'b0, 16'd4);
        tick(); chk_main("en_off_end", 5'b00000, 1'b0, 1'b0, 1'b1, 16'd5);
        tick(); chk_main("en_off_idle", 5'b00000, 1'b0, 1'b0, 1'b0, 16'd5);

        // Three step pulses while IDLE collapse into one pending step.
        step_mode = 1'b1; step = 1'b1;
        tick(); tick(); tick();
        step = 1'b0;
        chk_main("steps_idle", 5'b00000, 1'b0, 1'b0, 1'b0, 16'd5);
        en = 1'b1;
        tick(); chk_main("step_start", 5'b00001, 1'b1, 1'b1, 1'b0, 16'd5);
        for (int i = 1; i < 5; i++) begin
            tick();
            chk_main($sformatf("step_p%0d", i), 5'b00001 << i, 1'b1, 1'b0, 1'b0, 16'd5);
        end
        tick(); chk_main("step_gap", 5'b00000, 1'b1, 1'b0, 1'b0, 16'd5);
        tick(); chk_main("step_end", 5'b00000, 1'b0, 1'b0, 1'b1, 16'd6);
        tick(); chk_main("step_idle", 5'b00000, 1'b0, 1'b0, 1'b0, 16'd6);

        // Halt clears a pending step.
        en = 1'b0; step = 1'b1;
        tick(); step = 1'b0; halt = 1'b1;
        tick(); halt = 1'b0; en = 1'b1;
        tick(); chk_main("halt_clears_step", 5'b00000, 1'b0, 1'b0, 1'b0, 16'd6);

        // Async reset asserted mid-GAP.
        step_mode = 1'b0;
        tick(); chk_main("pre_rst_run", 5'b00001, 1'b1, 1'b1, 1'b0, 16'd6);
        tick(); tick(); tick(); tick(); tick();
        chk("pre_rst.slot", 32'(slot), 32'd5);
        rst_n = 1'b0;
        #1;
        chk_main("rst_mid_gap", 5'b00000, 1'b0, 1'b0, 1'b0, 16'd0);
        chk("rst_mid_gap.slot", 32'(slot), 32'd0);
        en = 1'b0;
        tick(); rst_n = 1'b1;

        // NUM_PHASES=4, GAP_CYCLES=0: period 4, no zero slot.
        chk("g0_reset.phase", 32'(phase4), 32'd0);
        rst4_n = 1'b1; en4 = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("g0_%0d.phase", i), 32'(phase4), 32'(4'b0001 << (i % 4)));
            chk($sformatf("g0_%0d.slot", i), 32'(slot4), 32'(i % 4));
            chk($sformatf("g0_%0d.start", i), 32'(start4), 32'((i % 4) == 0));
            chk($sformatf("g0_%0d.done", i), 32'(done4), 32'((i % 4) == 0 && i > 0));
            chk($sformatf("g0_%0d.count", i), 32'(count4), 32'(i / 4));
            chk($sformatf("g0_%0d.busy", i), 32'(busy4), 32'd1);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/phase_seq_gen.md
# phase_seq_gen

Parametrised multi-phase sequencer generating one-hot phase strobes for the processor's instruction-cycle stages (fetch, decode, execute, …). Successor to the fixed five-phase divider. Adds:
- configurable phase and idle-gap counts;
- enable;
- free-run and single-step modes;
- stall hold and synchronous halt;
- cycle-boundary status outputs.

Sits between the board clock and the PC/datapath control logic.

## Interface
- NUM_PHASES, 5, phase strobes per instruction cycle; legal range ≥2.
- GAP_CYCLES, 1, idle slots after the last phase with all strobes low; legal range ≥0.
- CYC_W, 16, width of the completed-cycle counter.
- CNT_W, derived, $clog2(NUM_PHASES+GAP_CYCLES), minimum 1; not overridable.

Ports:
- clk_in  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  run enable; sampled only at cycle boundaries and in IDLE.
- step_mode  input  1  1 = single-step, 0 = free-run.
- step  input  1  single-step request pulse; latched.
- stall  input  1  hold the current slot; no advance.
- halt  input  1  synchronous abort to IDLE; overrides everything except reset.
- phase  output  NUM_PHASES  one-hot phase strobes; all zero outside RUN.
- slot  output  CNT_W  current slot index.
- busy  output  1  state ≠ IDLE.
- cycle_start  output  1  registered one-clock pulse when slot 0 of a new cycle is entered.
- cycle_done  output  1  registered one-clock pulse after the final slot of a cycle completes.
- cycle_count  output  CYC_W  completed cycles; wraps modulo 2^CYC_W.

## Operation
- TOTAL = NUM_PHASES+GAP_CYCLES slots per cycle. Each slot is one clk_in cycle unless stalled.
- Reset values:
  - state IDLE, slot 0, phase 0;
  - busy 0, cycle_start 0, cycle_done 0, cycle_count 0;
  - step_pending 0.
- States:
  - IDLE: no strobes.
  - RUN: slot 0..NUM_PHASES-1, phase[slot]=1.
  - GAP: slot NUM_PHASES..TOTAL-1, phase=0.
- Start condition GO = en && (!step_mode || step_pending || step).
- IDLE: if GO, go to RUN with slot 0. Otherwise stay.
- RUN/GAP with stall=1: slot, state and strobes hold; no pulses.
- RUN, not last phase: slot+1.
- RUN, last phase: GAP with slot+1 if GAP_CYCLES>0; otherwise take the boundary action.
- GAP, not last slot: slot+1.
- GAP, slot TOTAL-1: take the boundary action.
- Boundary action:
  - cycle_done=1 and cycle_count+1 on the next cycle;
  - if GO, go to RUN with slot 0 and pulse cycle_start, back-to-back with no IDLE slot;
  - otherwise go to IDLE with slot 0.
- step_pending:
  - set by step=1 in any state;
  - cleared on the edge that enters slot 0 while step_mode=1;
  - multiple steps while pending collapse to one;
  - a step coinciding with the consuming edge is consumed, not re-latched.
- en or step_mode changes mid-cycle: the current cycle always completes. New values take effect only at the boundary.
- halt=1:
  - next edge forces IDLE, slot 0, phase 0;
  - clears step_pending;
  - no cycle_done, cycle_count unchanged;
  - takes priority over stall and over a simultaneous boundary.
- stall and boundary in the same cycle: stall wins. cycle_done is deferred until the slot actually advances.
- Outputs are decoded from registers only; no combinational input-to-output path.

## Timing
- Latency from IDLE: GO sampled at edge k gives phase[0] high after edge k, so phase[0] is visible in cycle k+1.
- Free-run period: exactly TOTAL cycles with stall=0. With defaults, phase = 00001, 00010, 00100, 01000, 10000, 00000, repeating.
- cycle_start coincides with phase[0]'s first cycle. In free-run, cycle_done coincides with it too.
- Stall of n cycles lengthens the current slot by n cycles.
- Reset assertion clears all state immediately, mid-cycle included. Release is synchronised by the board-level reset conditioner.

## Structure
- Shared package/header phase_seq_pkg: state encoding (IDLE=2'd0, RUN=2'd1, GAP=2'd2) and a clog2 constant function.
- One sub-module: phase_onehot_dec, which decodes slot and RUN state to the one-hot phase vector, parametrised by NUM_PHASES and CNT_W.
- Top level holds the FSM, slot counter, step_pending latch and cycle counter.

## Test plan
- Defaults, en=1, step_mode=0, after reset release: phase sequence 1,2,4,8,16,0, repeating with a period of 6. cycle_count reads 3 after 18 cycles from the first phase.
- NUM_PHASES=4, GAP_CYCLES=0: period 4 with no zero slot. cycle_start and cycle_done both high on every phase[0] after the first.
- step_mode=1, three step pulses in consecutive cycles while IDLE: exactly one cycle runs (5 strobes, 1 gap), then IDLE with busy=0.
- stall=1 for 3 cycles during phase[2]: phase stays 00100 for 4 cycles. Period becomes 9. cycle_done is delayed by 3.
- halt during phase[3]: next cycle phase=0, busy=0, cycle_count unchanged. Restart begins at phase[0].
- rst_n low mid-GAP: all outputs 0 immediately. en deasserted mid-cycle: the cycle completes, one cycle_done, then IDLE.
